// File: rtl/sync_downcount_pkg.sv
// Shared definitions for the sync_downcount presettable down counter.
// State encodings, state width and default counter width.
package sync_downcount_pkg;

    localparam int SDC_STATE_W       = 2;
    localparam int SDC_WIDTH_DEFAULT = 4;

    // Code 3 is illegal and recovers to SDC_IDLE.
    typedef enum logic [SDC_STATE_W-1:0] {
        SDC_IDLE    = 2'd0,
        SDC_RUN     = 2'd1,
        SDC_EXPIRED = 2'd2
    } sdc_state_e;

endpackage

// File: rtl/sync_downcount_if.sv
// Control/status bundle of sync_downcount: enable, load, start value and count status.
interface sync_downcount_if
    import sync_downcount_pkg::*;
#(
    parameter int WIDTH = SDC_WIDTH_DEFAULT
);

    logic             en;
    logic             load;
    logic [WIDTH-1:0] din;
    logic [WIDTH-1:0] out;
    logic             zero;
    logic             busy;
    logic             done;

    modport master (
        output en, load, din,
        input  out, zero, busy, done
    );

    modport slave (
        input  en, load, din,
        output out, zero, busy, done
    );

endinterface

// File: rtl/sync_downcount_next_count.sv
// sdc_next_count: combinational next-count and expiry detection for sync_downcount.
// SYNC_DOWNCOUNT_AUTO_RELOAD_EN selects reload-from-zero instead of holding at zero.
module sdc_next_count
    import sync_downcount_pkg::*;
#(
    parameter int WIDTH = SDC_WIDTH_DEFAULT
) (
    input  logic [WIDTH-1:0] out,
    input  logic [WIDTH-1:0] reload,
    input  logic             en,
    input  sdc_state_e       state,
    output logic [WIDTH-1:0] next_out,
    output logic             expire
);

    always_comb begin
        next_out = out;
        expire   = 1'b0;
        if (state == SDC_RUN && en) begin
            if (out > WIDTH'(1)) begin
                next_out = out - WIDTH'(1);
            end else if (out == WIDTH'(1)) begin
                next_out = '0;
                expire   = 1'b1;
            end else begin
`ifdef SYNC_DOWNCOUNT_AUTO_RELOAD_EN
                next_out = reload;
`else
                // Saturate: never borrow below zero.
                next_out = '0;
`endif
            end
        end
    end

`ifndef SYNC_DOWNCOUNT_AUTO_RELOAD_EN
    logic unused_reload;
    assign unused_reload = ^reload;
`endif

endmodule

// File: rtl/sync_downcount.sv
// sync_downcount: presettable synchronous down counter with one-cycle done pulse.
// Optional macro SYNC_DOWNCOUNT_AUTO_RELOAD_EN turns it into a periodic timer.
module sync_downcount
    import sync_downcount_pkg::*;
#(
    parameter int WIDTH = SDC_WIDTH_DEFAULT
) (
    input  logic              ck,
    input  logic              rst,
    sync_downcount_if.slave   bus
);

    sdc_state_e       state_q, state_d;
    logic [WIDTH-1:0] out_q, out_d;
    logic [WIDTH-1:0] reload_q, reload_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] next_out;
    logic             expire;

    sdc_next_count #(.WIDTH(WIDTH)) u_next_count (
        .out      (out_q),
        .reload   (reload_q),
        .en       (bus.en),
        .state    (state_q),
        .next_out (next_out),
        .expire   (expire)
    );

    always_comb begin
        state_d  = state_q;
        out_d    = out_q;
        reload_d = reload_q;
        done_d   = 1'b0;
        if (bus.load) begin
            out_d    = bus.din;
            reload_d = bus.din;
            state_d  = (bus.din != '0) ? SDC_RUN : SDC_IDLE;
        end else begin
            case (state_q)
                SDC_RUN: begin
                    out_d  = next_out;
                    done_d = expire;
`ifndef SYNC_DOWNCOUNT_AUTO_RELOAD_EN
                    if (expire) state_d = SDC_EXPIRED;
`endif
                end
                SDC_IDLE, SDC_EXPIRED: begin
                    out_d = '0;
                end
                default: begin
                    state_d = SDC_IDLE;
                    out_d   = '0;
                end
            endcase
        end
        busy_d = (state_d == SDC_RUN);
    end

    always_ff @(posedge ck) begin
        if (!rst) begin
            state_q  <= SDC_IDLE;
            out_q    <= '0;
            reload_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            out_q    <= out_d;
            reload_q <= reload_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign bus.out  = out_q;
    assign bus.zero = (out_q == '0);
    assign bus.busy = busy_q;
    assign bus.done = done_q;

endmodule

// File: tb/tb_sync_downcount.sv
// Self-checking bench for sync_downcount: directed sequences plus randomized traffic
// compared every cycle against a behavioural countdown model.
module tb_sync_downcount;

    localparam int WIDTH = 4;
`ifdef SYNC_DOWNCOUNT_AUTO_RELOAD_EN
    localparam bit AUTO = 1'b1;
`else
    localparam bit AUTO = 1'b0;
`endif

    logic ck;
    logic rst;
    int   errors = 0;
    int   checks = 0;

    sync_downcount_if #(.WIDTH(WIDTH)) bus ();

    sync_downcount #(.WIDTH(WIDTH)) dut (
        .ck  (ck),
        .rst (rst),
        .bus (bus)
    );

    initial ck = 1'b0;
    always #5 ck = ~ck;

    // Behavioural model: remaining count, running flag, remembered start value.
    int m_cnt     = 0;
    bit m_running = 0;
    int m_reload  = 0;
    bit m_done    = 0;

    always @(posedge ck) begin
        bit s_rst, s_load, s_en;
        int s_din;
        logic [WIDTH-1:0] exp_out;
        s_rst  = rst;
        s_load = bus.load;
        s_en   = bus.en;
        s_din  = int'(bus.din);
        m_done = 0;
        if (!s_rst) begin
            m_cnt = 0; m_running = 0; m_reload = 0;
        end else if (s_load) begin
            m_cnt = s_din; m_reload = s_din; m_running = (s_din != 0);
        end else if (m_running && s_en) begin
            if (m_cnt == 0) begin
                m_cnt = m_reload;
            end else begin
                m_cnt = m_cnt - 1;
                if (m_cnt == 0) begin
                    m_done = 1;
                    if (!AUTO) m_running = 0;
                end
            end
        end
        #1;
        exp_out = m_cnt[WIDTH-1:0];
        checks += 4;
        if (bus.out !== exp_out) begin
            errors++;
            $display("FAIL model_out t=%0t got=%0d exp=%0d", $time, bus.out, exp_out);
        end
        if (bus.zero !== (m_cnt == 0)) begin
            errors++;
            $display("FAIL model_zero t=%0t got=%b exp=%b", $time, bus.zero, (m_cnt == 0));
        end
        if (bus.busy !== m_running) begin
            errors++;
            $display("FAIL model_busy t=%0t got=%b exp=%b", $time, bus.busy, m_running);
        end
        if (bus.done !== m_done) begin
            errors++;
            $display("FAIL model_done t=%0t got=%b exp=%b", $time, bus.done, m_done);
        end
    end

    task automatic step(input bit r, input bit ld, input bit e, input int d);
        @(negedge ck);
        rst      = r;
        bus.load = ld;
        bus.en   = e;
        bus.din  = d[WIDTH-1:0];
        @(posedge ck);
        #2;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s got=%0d exp=%0d", name, act, exp);
        end
    endtask

    task automatic chk_status(input string name, input int o, input int b, input int dn);
        chk({name, "_out"},  int'(bus.out),  o);
        chk({name, "_busy"}, int'(bus.busy), b);
        chk({name, "_done"}, int'(bus.done), dn);
    endtask

    initial begin
        int n;
        int exp_seq [9];
        rst = 1'b0; bus.load = 1'b0; bus.en = 1'b0; bus.din = '0;

        // Reset dominates load
        step(0, 1, 0, 9);
        step(0, 1, 0, 9);
        chk_status("reset", 0, 0, 0);
        chk("reset_zero", int'(bus.zero), 1);

`ifndef SYNC_DOWNCOUNT_AUTO_RELOAD_EN
        // One-shot countdown
        step(1, 1, 0, 3);  chk_status("os_load", 3, 1, 0);
        step(1, 0, 1, 0);  chk_status("os_t1", 2, 1, 0);
        step(1, 0, 1, 0);  chk_status("os_t2", 1, 1, 0);
        step(1, 0, 1, 0);  chk_status("os_t3", 0, 0, 1);
        chk("os_zero", int'(bus.zero), 1);
        step(1, 0, 1, 0);  chk_status("os_after", 0, 0, 0);
`else
        // Periodic reload
        exp_seq = '{1, 0, 2, 1, 0, 2, 1, 0, 2};
        step(1, 1, 0, 2);  chk_status("ar_load", 2, 1, 0);
        for (int i = 0; i < 9; i++) begin
            step(1, 0, 1, 0);
            chk_status($sformatf("ar_t%0d", i), exp_seq[i], 1, (exp_seq[i] == 0) ? 1 : 0);
        end
`endif

        // Pause
        step(1, 1, 0, 5);  chk("pause_load", int'(bus.out), 5);
        step(1, 0, 1, 0);  chk("pause_1", int'(bus.out), 4);
        step(1, 0, 0, 0);  chk("pause_2", int'(bus.out), 4);
        step(1, 0, 0, 0);  chk("pause_3", int'(bus.out), 4);
        step(1, 0, 1, 0);  chk("pause_4", int'(bus.out), 3);
        step(1, 0, 1, 0);  chk_status("pause_5", 2, 1, 0);

        // Restart mid-count: load beats en
        step(1, 1, 0, 7);
        for (int i = 0; i < 3; i++) step(1, 0, 1, 0);
        chk("restart_pre", int'(bus.out), 4);
        step(1, 1, 1, 2);  chk_status("restart", 2, 1, 0);
        step(1, 1, 1, 0);  chk_status("load0", 0, 0, 0);

        // Reset mid-count aborts without done
        step(1, 1, 0, 6);
        step(1, 0, 1, 0);
        step(1, 0, 1, 0);  chk("rmid_pre", int'(bus.out), 4);
        step(0, 0, 1, 0);  chk_status("rmid_rst", 0, 0, 0);
        step(1, 0, 1, 0);  chk_status("rmid_idle", 0, 0, 0);

        // Max start value: done after exactly 15 enabled ticks
        step(1, 1, 0, 15);
        n = 0;
        for (int i = 0; i < 20; i++) begin
            step(1, 0, 1, 0);
            n++;
            if (bus.done === 1'b1) break;
        end
        chk("ticks15", n, 15);

        // Randomized traffic, checked by the model process
        for (int i = 0; i < 3000; i++) begin
            bit r, ld, e;
            int d;
            r  = ($urandom_range(0, 39) != 0);
            ld = ($urandom_range(0, 7) == 0);
            e  = ($urandom_range(0, 3) != 0);
            case ($urandom_range(0, 5))
                0:       d = 0;
                1:       d = 1;
                default: d = int'($urandom_range(0, (1 << WIDTH) - 1));
            endcase
            step(r, ld, e, d);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
